axis_video_pattern_gen: RTL and testbench

AXIS_VIDEO_PATTERN_GEN -- requirements
Module: axis_video_pattern_gen

---
 rtl/axis_video_pattern_gen_if.sv | 14 +
 rtl/axis_video_pattern_gen.sv | 212 +++++++++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern generator and its sink.
// DATA_W must equal BITS_PER_PIXEL * PIXEL_PER_CLK of the attached generator.
interface axis_video_pattern_gen_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern generator: solid, gradient, colour bars, checker.
// Optional macro AXIS_VPG_FRAME_ID_EN puts an 8-bit frame counter into the alpha byte.
module axis_video_pattern_gen #(
  parameter int IMAGE_WIDTH    = 960,
  parameter int IMAGE_HEIGHT   = 540,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  parameter int FRAME_GAP      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [1:0]          pattern_sel,
  axis_video_pattern_gen_if.master m_axis_video_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int DW    = BITS_PER_PIXEL * PIXEL_PER_CLK;
  localparam int XW    = $clog2(IMAGE_WIDTH + 1);
  localparam int YW    = $clog2(IMAGE_HEIGHT + 1);
  localparam int GW    = $clog2(FRAME_GAP + 1);
  localparam int BAR_W = (IMAGE_WIDTH / 8 > 0) ? IMAGE_WIDTH / 8 : 1;

  localparam logic [XW-1:0] LAST_X   = XW'(IMAGE_WIDTH - PIXEL_PER_CLK);
  localparam logic [XW-1:0] STEP_X   = XW'(PIXEL_PER_CLK);
  localparam logic [YW-1:0] LAST_Y   = YW'(IMAGE_HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, x_nxt;
  logic [YW-1:0]   y_q, y_d, y_nxt;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      pat_q, pat_d, pat_use;
  logic [DW-1:0]   tdata_q, tdata_d, beat;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            tuser_q, tuser_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;
  logic            last_beat;
  logic [7:0]      alpha;

`ifdef AXIS_VPG_FRAME_ID_EN
  logic [7:0] fid_q, fid_d;
  assign alpha = fid_q;
`else
  assign alpha = 8'hFF;
`endif

  // One pixel, laid out B[31:24] G[23:16] R[15:8] A[7:0].
  function automatic logic [31:0] pixel(input logic [1:0] pat, input logic [31:0] col,
                                        input logic [31:0] row, input logic [7:0] a);
    logic [31:0] bar;
    logic [2:0]  c;
    pixel = {24'h000000, a};
    case (pat)
      2'd0: pixel[31:8] = 24'hFFFFFF;
      2'd1: pixel[31:8] = {col[7:0], col[7:0], col[7:0]};
      2'd2: begin
        bar = col / 32'(BAR_W);
        if (bar > 32'd7) bar = 32'd7;
        c = 3'(32'd7 - bar);
        pixel[31:24] = {8{c[0]}};
        pixel[23:16] = {8{c[1]}};
        pixel[15:8]  = {8{c[2]}};
      end
      default: pixel[31:8] = {24{col[3] ^ row[3]}};
    endcase
  endfunction

  assign last_beat = (x_q == LAST_X) && (y_q == LAST_Y);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    x_nxt    = x_q;
    y_nxt    = y_q;
    pat_use  = pat_q;
`ifdef AXIS_VPG_FRAME_ID_EN
    fid_d    = fid_q;
`endif
    case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d = ACTIVE;
          pat_d   = pattern_sel;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
        end
      end
      ACTIVE: begin
        // First cycle after leaving IDLE only primes the output register.
        if (!tvalid_q) begin
          load     = 1'b1;
          tvalid_d = 1'b1;
        end else if (m_axis_video_out.tready) begin
          if (last_beat) begin
            state_d  = GAP;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            done_d   = 1'b1;
            gap_d    = '0;
            x_d      = '0;
            y_d      = '0;
`ifdef AXIS_VPG_FRAME_ID_EN
            fid_d    = fid_q + 8'd1;
`endif
          end else begin
            if (x_q == LAST_X) begin
              x_nxt = '0;
              y_nxt = y_q + YW'(1);
            end else begin
              x_nxt = x_q + STEP_X;
            end
            x_d  = x_nxt;
            y_d  = y_nxt;
            load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (continuous) begin
            // Back-to-back frames present beat 0 straight away, so the idle run is FRAME_GAP cycles.
            state_d  = ACTIVE;
            pat_d    = pattern_sel;
            pat_use  = pattern_sel;
            x_nxt    = '0;
            y_nxt    = '0;
            load     = 1'b1;
            tvalid_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    beat = '0;
    for (int i = 0; i < PIXEL_PER_CLK; i++)
      beat[i*32 +: 32] = pixel(pat_use, 32'(x_nxt) + 32'(i), 32'(y_nxt), alpha);
    if (load) begin
      tdata_d = beat;
      tlast_d = (x_nxt == LAST_X);
      tuser_d = (x_nxt == '0) && (y_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= '0;
      pat_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef AXIS_VPG_FRAME_ID_EN
      fid_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gap_q    <= gap_d;
      pat_q    <= pat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef AXIS_VPG_FRAME_ID_EN
      fid_q    <= fid_d;
`endif
    end
  end

  assign m_axis_video_out.tdata  = tdata_q;
  assign m_axis_video_out.tvalid = tvalid_q;
  assign m_axis_video_out.tlast  = tlast_q;
  assign m_axis_video_out.tuser  = tuser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen: 8x2 frames at 1 and 4 pixels per beat.
`timescale 1ns/1ps
module tb_axis_video_pattern_gen;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic         user;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, cont_a, rdy_a, busy_a, done_a;
  logic [1:0] pat_a;
  logic       start_b, busy_b, done_b;

  int errs = 0;
  int checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int acc_a = 0, acc_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int gap_checks = 0, gap_run = 0;
  bit armed = 0, prev_done_a = 0, prev_stall = 0;
  logic [31:0] held_data;
  logic        held_last, held_user;

  always #5 clk = ~clk;

  axis_video_pattern_gen_if #(.DATA_W(32))  vid_a ();
  axis_video_pattern_gen_if #(.DATA_W(128)) vid_b ();
  assign vid_a.tready = rdy_a;
  assign vid_b.tready = 1'b1;

  axis_video_pattern_gen #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .PIXEL_PER_CLK(1),
                           .BITS_PER_PIXEL(32), .FRAME_GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .pattern_sel(pat_a),
    .m_axis_video_out(vid_a), .busy(busy_a), .frame_done(done_a));

  axis_video_pattern_gen #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .PIXEL_PER_CLK(4),
                           .BITS_PER_PIXEL(32), .FRAME_GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(1'b0), .pattern_sel(2'd2),
    .m_axis_video_out(vid_b), .busy(busy_b), .frame_done(done_b));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] alpha(input int fid);
`ifdef AXIS_VPG_FRAME_ID_EN
    return 8'(fid);
`else
    return 8'hFF;
`endif
  endfunction

  // 8x2 frame for the 1-pixel DUT; checker is all-dark since x<8 and y<2.
  task automatic push_frame_a(input logic [1:0] pat, input logic [7:0] a);
    exp_t e;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++) begin
        e.data = '0;
        case (pat)
          2'd0:    e.data[31:0] = {24'hFFFFFF, a};
          2'd1:    e.data[31:0] = {8'(x), 8'(x), 8'(x), a};
          default: e.data[31:0] = {24'h000000, a};
        endcase
        e.last = (x == 7);
        e.user = (x == 0) && (y == 0);
        q_a.push_back(e);
      end
  endtask

  // Monitor for the 1-pixel DUT.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall  = 0;
      armed       = 0;
      prev_done_a = 0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {vid_a.tvalid, vid_a.tdata, vid_a.tlast, vid_a.tuser},
              {1'b1, held_data, held_last, held_user});
      end
      if (vid_a.tvalid && vid_a.tready) begin
        acc_a++;
        if (q_a.size() == 0) check("extra_beat_a", 1, 0);
        else begin
          e = q_a.pop_front();
          check("beat_a", {vid_a.tdata, vid_a.tlast, vid_a.tuser}, {e.data[31:0], e.last, e.user});
        end
      end
      prev_stall = vid_a.tvalid && !vid_a.tready;
      held_data  = vid_a.tdata;
      held_last  = vid_a.tlast;
      held_user  = vid_a.tuser;
      if (done_a) begin
        done_cnt_a++;
        check("done_pulse", prev_done_a, 0);
      end
      prev_done_a = done_a;
      if (vid_a.tvalid && armed) begin
        check("frame_gap", gap_run, 4);
        gap_checks++;
        armed = 0;
      end else if (done_a) begin
        armed   = 1;
        gap_run = 1;
      end else if (armed && !busy_a) armed = 0;
      else if (armed) gap_run++;
    end
  end

  // Monitor for the 4-pixel DUT.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (vid_b.tvalid) begin
        acc_b++;
        if (q_b.size() == 0) check("extra_beat_b", 1, 0);
        else begin
          e = q_b.pop_front();
          check("beat_b", {vid_b.tdata, vid_b.tlast, vid_b.tuser}, {e.data, e.last, e.user});
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic wait_a_idle(input string name);
    int n = 0;
    while ((busy_a || vid_a.tvalid || q_a.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check(name, (n < 400), 1);
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (done_cnt_a < target && n < 400) begin
      step();
      n++;
    end
    check("wait_done", (n < 400), 1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] a;
    int base, n;
    rst_n = 1'b0; start_a = 1'b0; cont_a = 1'b0; pat_a = 2'd0; rdy_a = 1'b1; start_b = 1'b0;
    repeat (3) step();
    check("rst_tvalid", vid_a.tvalid, 0);
    check("rst_tlast",  vid_a.tlast, 0);
    check("rst_tuser",  vid_a.tuser, 0);
    check("rst_busy",   busy_a, 0);
    check("rst_done",   done_a, 0);
    check("rst_tdata",  vid_a.tdata, 0);
    rst_n = 1'b1;
    step();

    // Single gradient frame; pattern change mid-frame must be ignored.
    push_frame_a(2'd1, alpha(0));
    pat_a = 2'd1; start_a = 1'b1;
    step();
    start_a = 1'b0; pat_a = 2'd3;
    check("lat_tvalid_lo", vid_a.tvalid, 0);
    check("lat_busy", busy_a, 1);
    step();
    check("lat_tvalid_hi", vid_a.tvalid, 1);
    check("lat_tuser", vid_a.tuser, 1);
    wait_a_idle("frame1_tmo");
    check("frame1_done", done_cnt_a, 1);
    check("frame1_beats", acc_a, 16);

    // Backpressure: tready 1,0,1,0...
    base = acc_a;
    push_frame_a(2'd1, alpha(1));
    pat_a = 2'd1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while ((busy_a || vid_a.tvalid || q_a.size() != 0) && n < 400) begin
      rdy_a = (n % 2 == 0);
      step();
      n++;
    end
    rdy_a = 1'b1;
    check("bp_tmo", (n < 400), 1);
    check("bp_beats", acc_a - base, 16);
    check("bp_done", done_cnt_a, 2);

    // Continuous: three frames, pattern switched during the first gap.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    base = done_cnt_a;
    push_frame_a(2'd3, alpha(0));
    push_frame_a(2'd0, alpha(1));
    push_frame_a(2'd0, alpha(2));
    pat_a = 2'd3; cont_a = 1'b1;
    wait_done_a(base + 1);
    pat_a = 2'd0;
    wait_done_a(base + 2);
    n = 0;
    while (!(vid_a.tvalid && vid_a.tuser) && n < 100) begin
      step();
      n++;
    end
    check("cont_f3_tmo", (n < 100), 1);
    cont_a = 1'b0;
    wait_a_idle("cont_tmo");
    check("cont_done", done_cnt_a - base, 3);
    check("cont_gaps", gap_checks, 2);

    // Reset in the middle of a frame.
    base = acc_a;
    push_frame_a(2'd1, alpha(3));
    pat_a = 2'd1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (acc_a - base < 5 && n < 100) begin
      step();
      n++;
    end
    check("abort_tmo", (n < 100), 1);
    base = done_cnt_a;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q_a.delete();
    check("abort_tvalid", vid_a.tvalid, 0);
    check("abort_tlast",  vid_a.tlast, 0);
    check("abort_tuser",  vid_a.tuser, 0);
    check("abort_busy",   busy_a, 0);
    check("abort_done",   done_a, 0);
    check("abort_tdata",  vid_a.tdata, 0);
    repeat (3) step();
    check("abort_no_done", done_cnt_a, base);
    push_frame_a(2'd1, alpha(0));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_a_idle("restart_tmo");
    check("restart_done", done_cnt_a, base + 1);

    // Four pixels per beat, colour bars.
    a = alpha(0);
    e.user = 1'b1; e.last = 1'b0;
    e.data = {{24'h0000FF, a}, {24'hFF00FF, a}, {24'h00FFFF, a}, {24'hFFFFFF, a}};
    q_b.push_back(e);
    e.user = 1'b0; e.last = 1'b1;
    e.data = {{24'h000000, a}, {24'hFF0000, a}, {24'h00FF00, a}, {24'hFFFF00, a}};
    q_b.push_back(e);
    e.user = 1'b0; e.last = 1'b0;
    e.data = {{24'h0000FF, a}, {24'hFF00FF, a}, {24'h00FFFF, a}, {24'hFFFFFF, a}};
    q_b.push_back(e);
    e.user = 1'b0; e.last = 1'b1;
    e.data = {{24'h000000, a}, {24'hFF0000, a}, {24'h00FF00, a}, {24'hFFFF00, a}};
    q_b.push_back(e);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while ((busy_b || vid_b.tvalid || q_b.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("ppc4_tmo", (n < 200), 1);
    check("ppc4_beats", acc_b, 4);
    check("ppc4_done", done_cnt_b, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
